// File: rtl/note_seq_pkg.sv
// Shared types and default sizes for the note record/playback sequencer.
package note_seq_pkg;

   localparam int unsigned NOTE_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 6;
   localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRec  = 2'd1,
      StPlay = 2'd2
   } seq_state_e;

endpackage

// File: rtl/seq_addr_counter.sv
// Note RAM pointer: clear has priority over increment; terminal flags the last entry.
module seq_addr_counter #(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] ptr_o,
   output logic              terminal_o
);

   logic [ADDR_W-1:0] ptr_d, ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o      = ptr_q;
   assign terminal_o = (ptr_q == '1);

endmodule

// File: rtl/note_sequencer.sv
// Record/playback sequencer driving the external note RAM.
// Define NOTE_SEQ_LOOP_EN to add the loop input (wrap playback with a gap beat).
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int unsigned NOTE_W = NOTE_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              beat,
   input  logic              start_record,
   input  logic              start_play,
   input  logic              stop,
`ifdef NOTE_SEQ_LOOP_EN
   input  logic              loop,
`endif
   input  logic [NOTE_W-1:0] note_in,
   input  logic [NOTE_W-1:0] ram_q,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_wren,
   output logic [NOTE_W-1:0] ram_data,
   output logic [NOTE_W-1:0] note_out,
   output logic [ADDR_W:0]   length,
   output logic [1:0]        state,
   output logic              full,
   output logic              done
);

   seq_state_e        state_d, state_q;
   logic [ADDR_W:0]   length_d, length_q;
   logic [NOTE_W-1:0] note_out_d, note_out_q;
   logic              full_d, full_q;
   logic              done_d, done_q;
   logic              ptr_hi_d, ptr_hi_q;
   logic              ptr_clr, ptr_inc, ptr_term, end_play;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   played;

   seq_addr_counter #(
      .ADDR_W (ADDR_W)
   ) u_ptr (
      .clk_i      (clk),
      .reset_i    (reset),
      .clr_i      (ptr_clr),
      .inc_i      (ptr_inc),
      .ptr_o      (ptr),
      .terminal_o (ptr_term)
   );

   // ptr_hi extends the pointer so a 64-note playback can reach length==64.
   assign played = {ptr_hi_q, ptr};

`ifdef NOTE_SEQ_LOOP_EN
   assign end_play = !loop;
`else
   assign end_play = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      length_d   = length_q;
      note_out_d = note_out_q;
      full_d     = full_q;
      done_d     = 1'b0;
      ptr_hi_d   = ptr_hi_q;
      ptr_clr    = 1'b0;
      ptr_inc    = 1'b0;
      ram_wren   = 1'b0;
      unique case (state_q)
         StIdle: begin
            ptr_clr  = 1'b1;
            ptr_hi_d = 1'b0;
            if (start_record) begin
               state_d  = StRec;
               length_d = '0;
               full_d   = 1'b0;
            end else if (start_play && (length_q != '0)) begin
               state_d    = StPlay;
               note_out_d = '0;
            end
         end
         StRec: begin
            if (stop) begin
               state_d = StIdle;
               done_d  = 1'b1;
               ptr_clr = 1'b1;
            end else if (beat) begin
               ram_wren = 1'b1;
               ptr_inc  = 1'b1;
               length_d = {1'b0, ptr} + (ADDR_W + 1)'(1);
               if (ptr_term) begin
                  full_d  = 1'b1;
                  state_d = StIdle;
                  done_d  = 1'b1;
                  ptr_clr = 1'b1;
               end
            end
         end
         StPlay: begin
            if (stop) begin
               note_out_d = '0;
               state_d    = StIdle;
               done_d     = 1'b1;
               ptr_clr    = 1'b1;
               ptr_hi_d   = 1'b0;
            end else if (beat) begin
               if (played == length_q) begin
                  note_out_d = '0;
                  ptr_clr    = 1'b1;
                  ptr_hi_d   = 1'b0;
                  if (end_play) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end else begin
                  note_out_d = ram_q;
                  ptr_inc    = 1'b1;
                  if (ptr_term) begin
                     ptr_hi_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
            ptr_clr = 1'b1;
         end
      endcase
      if (reset) begin
         ram_wren = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         length_q   <= '0;
         note_out_q <= '0;
         full_q     <= 1'b0;
         done_q     <= 1'b0;
         ptr_hi_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         length_q   <= length_d;
         note_out_q <= note_out_d;
         full_q     <= full_d;
         done_q     <= done_d;
         ptr_hi_q   <= ptr_hi_d;
      end
   end

   assign ram_address = ptr;
   assign ram_data    = note_in;
   assign note_out    = note_out_q;
   assign length      = length_q;
   assign state       = state_q;
   assign full        = full_q;
   assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: vector table, directed corner sequences, random vs. reference model.
module tb_note_sequencer;
   import note_seq_pkg::*;

`ifdef NOTE_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, beat, start_record, start_play, stop, loop;
   logic [31:0] note_in, ram_q, ram_data, note_out;
   logic [5:0]  ram_address;
   logic        ram_wren, full, done;
   logic [6:0]  length;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   note_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .beat         (beat),
      .start_record (start_record),
      .start_play   (start_play),
      .stop         (stop),
`ifdef NOTE_SEQ_LOOP_EN
      .loop         (loop),
`endif
      .note_in      (note_in),
      .ram_q        (ram_q),
      .ram_address  (ram_address),
      .ram_wren     (ram_wren),
      .ram_data     (ram_data),
      .note_out     (note_out),
      .length       (length),
      .state        (state),
      .full         (full),
      .done         (done)
   );

   // Registered-read RAM with a log of every write it captures.
   logic [31:0] mem [64];
   logic [5:0]  wlog_addr [$];
   logic [31:0] wlog_data [$];
   always @(posedge clk) begin
      if (ram_wren) begin
         mem[ram_address] <= ram_data;
         wlog_addr.push_back(ram_address);
         wlog_data.push_back(ram_data);
      end
      ram_q <= mem[ram_address];
   end

   // Reference model: plain counters plus the list of notes it believes were recorded.
   int          m_st, m_ptr, m_len;
   bit          m_full, m_done;
   logic [31:0] m_out;
   logic [31:0] m_rec [64];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic b, input logic sr, input logic sp, input logic st,
                      input logic lp, input logic [31:0] n, input logic rst);
      bit exp_wren;
      beat = b; start_record = sr; start_play = sp; stop = st; loop = lp;
      note_in = n; reset = rst;
      #3;
      exp_wren = !rst && (m_st == 1) && b && !st;
      chk("ram_wren", ram_wren, exp_wren);
      if (exp_wren) begin
         chk("ram_address_wr", ram_address, m_ptr % 64);
         chk("ram_data", ram_data, n);
      end
      if (rst) begin
         m_st = 0; m_ptr = 0; m_len = 0; m_full = 0; m_done = 0; m_out = '0;
      end else begin
         m_done = 0;
         case (m_st)
            0: begin
               if (sr) begin
                  m_st = 1; m_ptr = 0; m_len = 0; m_full = 0;
               end else if (sp && m_len > 0) begin
                  m_st = 2; m_ptr = 0; m_out = '0;
               end
            end
            1: begin
               if (st) begin
                  m_st = 0; m_done = 1; m_ptr = 0;
               end else if (b) begin
                  m_rec[m_ptr] = n;
                  m_ptr++;
                  m_len = m_ptr;
                  if (m_ptr == 64) begin
                     m_full = 1; m_st = 0; m_done = 1; m_ptr = 0;
                  end
               end
            end
            default: begin
               if (st) begin
                  m_out = '0; m_st = 0; m_done = 1; m_ptr = 0;
               end else if (b) begin
                  if (m_ptr < m_len) begin
                     m_out = m_rec[m_ptr];
                     m_ptr++;
                  end else begin
                     m_out = '0;
                     m_ptr = 0;
                     if (!(LOOP_EN && lp)) begin
                        m_st = 0; m_done = 1;
                     end
                  end
               end
            end
         endcase
      end
      @(posedge clk);
      #1;
      chk("state", state, m_st);
      chk("length", length, m_len);
      chk("full", full, m_full);
      chk("done", done, m_done);
      chk("note_out", note_out, m_out);
      chk("ram_address", ram_address, m_ptr % 64);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 32'h0, 0);
   endtask

   typedef struct {
      logic        b, sr, sp, st;
      logic [31:0] n;
      logic [1:0]  e_state;
      logic [6:0]  e_len;
      logic [31:0] e_out;
      logic        e_done;
   } vec_t;

   vec_t vecs [17];
   int   wbase;
   bit   last_b;

   initial begin
      beat = 0; start_record = 0; start_play = 0; stop = 0; loop = 0;
      note_in = '0; reset = 1;
      @(posedge clk);
      #1;
      cyc(0, 0, 0, 0, 0, 32'h0, 1);
      chk("rst_state", state, 2'd0);
      chk("rst_length", length, 7'd0);
      chk("rst_note_out", note_out, 32'h0);

      // Record 1, 40, 1000 then stop; play back with 4 beats.
      vecs = '{
         '{0, 1, 0, 0, 32'h0,    2'd1, 7'd0, 32'h0,    1'b0},
         '{1, 0, 0, 0, 32'h1,    2'd1, 7'd1, 32'h0,    1'b0},
         '{0, 0, 0, 0, 32'h0,    2'd1, 7'd1, 32'h0,    1'b0},
         '{1, 0, 0, 0, 32'h40,   2'd1, 7'd2, 32'h0,    1'b0},
         '{0, 0, 0, 0, 32'h0,    2'd1, 7'd2, 32'h0,    1'b0},
         '{1, 0, 0, 0, 32'h1000, 2'd1, 7'd3, 32'h0,    1'b0},
         '{0, 0, 0, 1, 32'h0,    2'd0, 7'd3, 32'h0,    1'b1},
         '{0, 0, 0, 0, 32'h0,    2'd0, 7'd3, 32'h0,    1'b0},
         '{0, 0, 1, 0, 32'h0,    2'd2, 7'd3, 32'h0,    1'b0},
         '{1, 0, 0, 0, 32'h0,    2'd2, 7'd3, 32'h1,    1'b0},
         '{0, 0, 0, 0, 32'h0,    2'd2, 7'd3, 32'h1,    1'b0},
         '{1, 0, 0, 0, 32'h0,    2'd2, 7'd3, 32'h40,   1'b0},
         '{0, 0, 0, 0, 32'h0,    2'd2, 7'd3, 32'h40,   1'b0},
         '{1, 0, 0, 0, 32'h0,    2'd2, 7'd3, 32'h1000, 1'b0},
         '{0, 0, 0, 0, 32'h0,    2'd2, 7'd3, 32'h1000, 1'b0},
         '{1, 0, 0, 0, 32'h0,    2'd0, 7'd3, 32'h0,    1'b1},
         '{0, 0, 0, 0, 32'h0,    2'd0, 7'd3, 32'h0,    1'b0}
      };
      wbase = wlog_addr.size();
      for (int i = 0; i < 17; i++) begin
         cyc(vecs[i].b, vecs[i].sr, vecs[i].sp, vecs[i].st, 1'b0, vecs[i].n, 1'b0);
         chk($sformatf("vec%0d_state", i), state, vecs[i].e_state);
         chk($sformatf("vec%0d_length", i), length, vecs[i].e_len);
         chk($sformatf("vec%0d_note_out", i), note_out, vecs[i].e_out);
         chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      end
      chk("rec3_writes", wlog_addr.size() - wbase, 3);
      if (wlog_addr.size() - wbase == 3) begin
         chk("rec3_a0", {wlog_addr[wbase], wlog_data[wbase]}, {6'd0, 32'h1});
         chk("rec3_a1", {wlog_addr[wbase+1], wlog_data[wbase+1]}, {6'd1, 32'h40});
         chk("rec3_a2", {wlog_addr[wbase+2], wlog_data[wbase+2]}, {6'd2, 32'h1000});
      end

      // Fill all entries; a further beat must not write.
      cyc(0, 1, 0, 0, 0, 32'h0, 0);
      wbase = wlog_addr.size();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 0, 0, 0, 0, 32'h100 + i, 0);
         if (i != DEPTH - 1) idle(1);
      end
      chk("fill_done", done, 1'b1);
      chk("fill_full", full, 1'b1);
      chk("fill_length", length, 7'd64);
      chk("fill_state", state, 2'd0);
      idle(1);
      cyc(1, 0, 0, 0, 0, 32'hdead, 0);
      chk("fill_writes", wlog_addr.size() - wbase, 64);
      for (int i = 0; i < DEPTH && i < wlog_addr.size() - wbase; i++) begin
         chk("fill_addr", wlog_addr[wbase+i], i);
      end
      // Play all 64 back, then the ending beat.
      cyc(0, 0, 1, 0, 0, 32'h0, 0);
      for (int i = 0; i <= DEPTH; i++) begin
         cyc(1, 0, 0, 0, 0, 32'h0, 0);
         idle(1);
      end
      chk("play64_state", state, 2'd0);

      // Stop beats a same-cycle beat; start_record beats start_play.
      cyc(0, 1, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 0, 32'h5, 0);
      idle(1);
      wbase = wlog_addr.size();
      cyc(1, 0, 0, 1, 0, 32'h6, 0);
      chk("stopbeat_nowrite", wlog_addr.size() - wbase, 0);
      chk("stopbeat_length", length, 7'd1);
      cyc(0, 1, 1, 0, 0, 32'h0, 0);
      chk("rec_prio_state", state, 2'd1);

      // Reset after 5 recorded beats; play with length 0 is ignored.
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 0, 0, 0, 32'h10 << i, 0);
         idle(1);
      end
      cyc(0, 0, 0, 0, 0, 32'h0, 1);
      chk("rst_mid_state", state, 2'd0);
      chk("rst_mid_length", length, 7'd0);
      cyc(1, 0, 1, 0, 0, 32'h0, 0);
      chk("play_len0_state", state, 2'd0);

`ifdef NOTE_SEQ_LOOP_EN
      cyc(0, 1, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 0, 32'haaaa, 0);
      idle(1);
      cyc(1, 0, 0, 1, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 0, 32'hbbbb, 0);
      idle(1);
      cyc(0, 1, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 0, 32'haaaa, 0);
      idle(1);
      cyc(1, 0, 0, 0, 0, 32'hbbbb, 0);
      cyc(0, 0, 0, 1, 0, 32'h0, 0);
      cyc(0, 0, 1, 0, 1, 32'h0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 0, 0, 1, 32'h0, 0);
         chk("loop_note", note_out, (i % 3 == 0) ? 32'haaaa : (i % 3 == 1) ? 32'hbbbb : 32'h0);
         chk("loop_nodone", done, 1'b0);
         cyc(0, 0, 0, 0, 1, 32'h0, 0);
      end
      cyc(0, 0, 0, 1, 1, 32'h0, 0);
      chk("loop_stop_done", done, 1'b1);
      chk("loop_stop_out", note_out, 32'h0);
`endif

      // Random traffic with beats kept at least two cycles apart.
      last_b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         logic b;
         b = !last_b && ($urandom_range(0, 2) == 0);
         last_b = b;
         cyc(b, $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
             $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom(),
             $urandom_range(0, 499) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Record/playback sequencer for the guitar note memory. Owns the 64-entry x 32-bit note RAM's address, write enable and write data, and the playback output register. Records one note per beat and tracks the recorded length. Plays back exactly that many notes, one per beat, then stops. Sits between the mode FSM (start/stop commands), the clock divider (beat pulse), the string/bar coordinate converter (note_in) and the audio/HEX display path (note_out).

## Interface
Parameters:
- NOTE_W, 32, width of one note word (string x bar one-hot map).
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- beat  in  1  one-cycle pulse per note period from the clock divider; consecutive pulses are at least 2 cycles apart.
- start_record  in  1  one-cycle command.
- start_play  in  1  one-cycle command.
- stop  in  1  one-cycle command.
- note_in  in  NOTE_W  converted note for the current beat.
- ram_q  in  NOTE_W  RAM read data, registered, 1-cycle read latency.
- ram_address  out  ADDR_W  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_data  out  NOTE_W  RAM write data.
- note_out  out  NOTE_W  note currently being played.
- length  out  ADDR_W+1  number of valid recorded notes, 0..64.
- state  out  2  IDLE=0, REC=1, PLAY=2.
- full  out  1  last recording filled all 64 entries.
- done  out  1  one-cycle pulse when a recording or playback ends.
- loop  in  1  wrap playback; present only when NOTE_SEQ_LOOP_EN is defined.

## Operation
- Reset values: state=IDLE, internal pointer=0, ram_address=0, ram_wren=0, note_out=0, length=0, full=0, done=0.
- ram_address is the pointer. In IDLE the pointer is held at 0, so ram_q always shows entry 0 there.
- **IDLE**
  - start_record: go to REC; pointer=0, length=0, full=0.
  - Otherwise, start_play with length>0: go to PLAY; pointer=0, note_out=0.
  - start_play with length==0 is ignored.
  - start_record has priority over start_play.
  - stop and beat are ignored.
- **REC**
  - On a beat cycle without stop:
    - ram_wren=1 (combinational, that cycle only) and ram_data=note_in.
    - The write lands at the current pointer on that clock edge.
    - pointer+1 and length=pointer+1.
  - The beat that writes entry 63 sets length=64 and full=1, pulses done, and returns to IDLE.
  - stop returns to IDLE and pulses done. length keeps the number already written.
  - stop wins over a same-cycle beat: no write happens.
- **PLAY**
  - On a beat cycle without stop, when pointer < length: note_out<=ram_q, pointer+1.
  - On a beat cycle when pointer == length (all notes shown): note_out<=0, go to IDLE, pulse done.
  - stop: note_out<=0, go to IDLE, pulse done. stop wins over a same-cycle beat.
- Commands arriving outside IDLE other than stop are ignored. length is not modified in PLAY.
- Reset mid-operation forces all reset values at the next edge, including ram_wren=0 and length=0.

## Timing
- Write: zero latency. Beat in cycle N produces ram_wren=1 in cycle N, and the RAM captures at the end of cycle N.
- Read: the pointer changes at edge N, and ram_q is valid in cycle N+1. Beat spacing ≥2 cycles guarantees ram_q is valid at every beat.
- The first PLAY beat may arrive in the first PLAY cycle, because the pointer was already 0 in IDLE.
- note_out updates on the edge ending the beat cycle and holds a full beat period.
- done is high for exactly one cycle: the first cycle after the transition to IDLE.
- The pointer wraps at 64 only via the full condition; it never silently overwrites entry 0.

## Configuration
- NOTE_SEQ_LOOP_EN defined:
  - The loop port exists.
  - In PLAY, when a beat finds pointer == length and loop=1: pointer<=0 and playback continues. note_out<=0 for that beat (gap beat), and done is not pulsed.
  - Only stop or loop=0 ends playback.
- Undefined: the loop port is absent and playback always ends after length notes.

## Structure
- Package note_seq_pkg holds:
  - the state enum (IDLE/REC/PLAY encodings);
  - default NOTE_W, ADDR_W;
  - the DEPTH = 2**ADDR_W constant.
- One sub-module, seq_addr_counter: ADDR_W-bit pointer with clear, increment and terminal flag. It is instantiated once and shared by REC and PLAY.
- The RAM stays outside this block.

## Test plan
- Record 3 notes: start_record, then beats with note_in=32'h1, 32'h40, 32'h1000, then stop. Expect 3 wren pulses at addresses 0,1,2 with matching data, length=3, done pulse, state=IDLE.
- Play back with a RAM model: start_play, then 4 beats. Expect note_out to go 32'h1, 32'h40, 32'h1000, then 0; done on the 4th beat; state=IDLE.
- Fill: start_record then 64 beats with no stop. Expect writes at addresses 0..63, length=64, full=1, done after beat 64; a 65th beat produces no write.
- Simultaneous events: stop and beat in the same REC cycle. Expect no write and length unchanged. start_play with length=0 is ignored. start_record and start_play together enter REC.
- Reset mid-record after 5 beats. Expect state=IDLE, length=0, ram_wren=0 next cycle; a following start_play is ignored.
- NOTE_SEQ_LOOP_EN defined, length=2, loop=1: beats give note_out A, B, 0, A, B with no done; stop then gives done and note_out=0.
